// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared width, state type and state constants for seq_divider
//
// Purpose : shared definitions for the iterative divider.
//           DIV_W   operand/result width
//           state_t 6-bit step counter type
//           S_LOAD  operand latch step
//           S_FIX   sign/zero correction step
//           S_DONE  result-ready step (counter saturates here)
package div_pkg;

   localparam int DIV_W = 32;

   typedef logic [5:0] state_t;

   localparam state_t S_LOAD = 6'd0;
   localparam state_t S_FIX  = 6'd33;
   localparam state_t S_DONE = 6'd34;

endpackage

// File: rtl/div_sign_fix.sv
// rtl/div_sign_fix.sv - floor-style sign correction of the raw magnitude quotient/remainder
//
// Purpose : turns the magnitude quotient/remainder into the final result.
//           With SEQ_DIVIDER_SIGNED_EN defined, floor-division sign fixes are applied
//           (remainder takes the divisor's sign). Without it, q0/r0 pass through.
//           A zero divisor always overrides: quot = all ones, rem = original dividend.
// Ports   : q0, r0    magnitude quotient / remainder
//           ay        divisor magnitude
//           neg_x     dividend was negative (signed mode)
//           neg_y     divisor was negative (signed mode)
//           zero      divisor was zero
//           x_lat     original, un-negated dividend
//           quot_n    corrected quotient
//           rem_n     corrected remainder
module div_sign_fix
   import div_pkg::*;
(
   input  logic [DIV_W-1:0] q0,
   input  logic [DIV_W-1:0] r0,
   input  logic [DIV_W-1:0] ay,
   input  logic             neg_x,
   input  logic             neg_y,
   input  logic             zero,
   input  logic [DIV_W-1:0] x_lat,
   output logic [DIV_W-1:0] quot_n,
   output logic [DIV_W-1:0] rem_n
);

`ifndef SEQ_DIVIDER_SIGNED_EN
   logic unused_sign;
   assign unused_sign = ^{ay, neg_x, neg_y};
`endif

   always_comb begin
      quot_n = q0;
      rem_n  = r0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      if (neg_x && neg_y) begin
         rem_n = -r0;
      end else if (neg_x ^ neg_y) begin
         if (r0 == '0) begin
            quot_n = -q0;
            rem_n  = '0;
         end else begin
            // -q0-1 is simply the bitwise complement
            quot_n = ~q0;
            rem_n  = neg_x ? (ay - r0) : (r0 - ay);
         end
      end
`endif
      if (zero) begin
         quot_n = '1;
         rem_n  = x_lat;
      end
   end

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - 34-cycle restoring divider with run/stall handshake
//
// Purpose : one quotient bit per cycle on operand magnitudes, then one
//           correction cycle. Build macro SEQ_DIVIDER_SIGNED_EN enables
//           signed floor-style division selected by op_unsigned = 0.
// Ports   : clk          rising-edge clock
//           rst          synchronous active-high reset
//           run          divide request, held until stall drops
//           op_unsigned  1 = unsigned, 0 = signed floor (sampled at S=0)
//           x, y         dividend / divisor (sampled at S=0)
//           stall        high while a requested divide is not finished
//           quot, rem    result registers, hold between operations
module seq_divider
   import div_pkg::*;
#(
   parameter int W = DIV_W
)
(
   input  logic         clk,
   input  logic         rst,
   input  logic         run,
   input  logic         op_unsigned,
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   output logic         stall,
   output logic [W-1:0] quot,
   output logic [W-1:0] rem
);

   state_t           s_q, s_d;
   logic [DIV_W:0]   r_q, r_d;
   logic [DIV_W-1:0] q_q, q_d;
   logic [DIV_W-1:0] ay_q, x_q;
   logic             neg_x_q, neg_y_q, zero_q;
   logic [DIV_W-1:0] quot_q, rem_q;

   logic             sgn;
   logic             neg_x_ld, neg_y_ld;
   logic [DIV_W-1:0] ax_ld, ay_ld;
   logic [DIV_W:0]   t;
   logic [DIV_W-1:0] quot_n, rem_n;

`ifdef SEQ_DIVIDER_SIGNED_EN
   assign sgn = ~op_unsigned;
`else
   logic unused_mode;
   assign unused_mode = op_unsigned;
   assign sgn         = 1'b0;
`endif

   assign neg_x_ld = x[DIV_W-1] & sgn;
   assign neg_y_ld = y[DIV_W-1] & sgn;
   assign ax_ld    = neg_x_ld ? -x : x;
   assign ay_ld    = neg_y_ld ? -y : y;

   // trial subtraction of the shifted partial remainder; t[32] is the borrow
   assign t = {r_q[DIV_W-1:0], q_q[DIV_W-1]} - {1'b0, ay_q};

   always_comb begin
      s_d = s_q;
      if (!run)
         s_d = S_LOAD;
      else if (s_q != S_DONE)
         s_d = s_q + 6'd1;
   end

   always_comb begin
      r_d = r_q;
      q_d = q_q;
      if (!t[DIV_W]) begin
         r_d = t;
         q_d = {q_q[DIV_W-2:0], 1'b1};
      end else begin
         r_d = {r_q[DIV_W-1:0], q_q[DIV_W-1]};
         q_d = {q_q[DIV_W-2:0], 1'b0};
      end
   end

   div_sign_fix u_sign_fix (
      .q0     (q_q),
      .r0     (r_q[DIV_W-1:0]),
      .ay     (ay_q),
      .neg_x  (neg_x_q),
      .neg_y  (neg_y_q),
      .zero   (zero_q),
      .x_lat  (x_q),
      .quot_n (quot_n),
      .rem_n  (rem_n)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         s_q     <= S_LOAD;
         r_q     <= '0;
         q_q     <= '0;
         ay_q    <= '0;
         x_q     <= '0;
         neg_x_q <= 1'b0;
         neg_y_q <= 1'b0;
         zero_q  <= 1'b0;
         quot_q  <= '0;
         rem_q   <= '0;
      end else begin
         s_q <= s_d;
         if (run) begin
            if (s_q == S_LOAD) begin
               neg_x_q <= neg_x_ld;
               neg_y_q <= neg_y_ld;
               ay_q    <= ay_ld;
               x_q     <= x;
               r_q     <= '0;
               q_q     <= ax_ld;
               zero_q  <= (y == '0);
            end else if (s_q < S_FIX) begin
               r_q <= r_d;
               q_q <= q_d;
            end else if (s_q == S_FIX) begin
               quot_q <= quot_n;
               rem_q  <= rem_n;
            end
         end
      end
   end

   // rst term keeps stall equal to run for the whole reset cycle
   assign stall = run & (rst | (s_q != S_DONE));
   assign quot  = quot_q;
   assign rem   = rem_q;

endmodule
